// File: rtl/serial_add_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_add_ctrl : bit-serial adder, LSB first, one full_add cell         |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+

module full_add (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_co;
  logic             fa_s;

  full_add u_full_add (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .co (fa_co),
    .s  (fa_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The carry flop holds the final carry-out from DONE until the next load.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign co   = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_add_ctrl : directed checks of serial_add_ctrl (WIDTH 8 and 1)  |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+

module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       ci8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       co8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       ci1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       co1;

  int n_vec;
  int n_err;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .ci    (ci8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .co    (co8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .ci    (ci1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .co    (co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles until done appears, bounded so a stuck DUT cannot hang the run.
  task automatic wait_done8(output int nb, output bit seen);
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1'b1;
        break;
      end
      if (busy8) nb++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic tci, input logic [7:0] es, input logic eco);
    int nb;
    bit seen;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = ta; b8 = tb; ci8 = tci;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~ta; b8 = ~tb; ci8 = ~tci;
    wait_done8(nb, seen);
    chk({tag, " busy cycles"}, nb, 8);
    chk({tag, " done seen"}, {31'd0, seen}, 1);
    chk({tag, " busy in done"}, {31'd0, busy8}, 0);
    chk({tag, " sum"}, {24'd0, sum8}, {24'd0, es});
    chk({tag, " co"}, {31'd0, co8}, {31'd0, eco});
    @(negedge clk);
    chk({tag, " done one cycle"}, {31'd0, done8}, 0);
    chk({tag, " sum held"}, {24'd0, sum8}, {24'd0, es});
    chk({tag, " co held"}, {31'd0, co8}, {31'd0, eco});
  endtask

  initial begin
    int  nb;
    bit  seen;
    int  n_done;
    logic [1:0] exp_tab [8];

    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;

    @(negedge clk);
    chk("rst busy8", {31'd0, busy8}, 0);
    chk("rst done8", {31'd0, done8}, 0);
    chk("rst sum8", {24'd0, sum8}, 0);
    chk("rst co8", {31'd0, co8}, 0);
    chk("rst busy1/done1", {30'd0, busy1, done1}, 0);
    #2 rst_n = 1'b1;

    op8("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    op8("ff+01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8("5a+a5+1",8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);
    op8("5a+a5",  8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0);
    op8("80+80+1",8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

    // Extra idle cycles must leave the last result untouched.
    repeat (3) @(negedge clk);
    chk("idle sum held", {24'd0, sum8}, 32'h01);
    chk("idle co held", {31'd0, co8}, 1);

    // start in the third RUN cycle carries other operands and must be ignored.
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F; ci8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(nb, seen);
    chk("midrun start busy left", nb, 5);
    chk("midrun start done", {31'd0, seen}, 1);
    chk("midrun start sum", {24'd0, sum8}, 32'h4B);
    chk("midrun start co", {31'd0, co8}, 0);
    @(negedge clk);
    chk("midrun start no rerun", {31'd0, busy8}, 0);

    // Reset dropped in the fourth RUN cycle aborts without a clock edge.
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort busy before", {31'd0, busy8}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy8}, 0);
    chk("abort sum", {24'd0, sum8}, 0);
    chk("abort co", {31'd0, co8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    chk("abort no done", n_done, 0);

    op8("post-rst", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

    // WIDTH=1 back-to-back with start held: {a,b,ci} = i[2:0].
    exp_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    @(posedge clk); #1;
    start1 = 1'b1; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("w1 busy %0d", i), {31'd0, busy1}, 1);
      @(posedge clk); #1;
      chk($sformatf("w1 done %0d", i), {31'd0, done1}, 1);
      chk($sformatf("w1 co,s %0d", i), {30'd0, co1, sum1}, {30'd0, exp_tab[i]});
      if (i < 7) begin
        a1  = 1'((i + 1) >> 2);
        b1  = 1'((i + 1) >> 1);
        ci1 = 1'(i + 1);
      end else begin
        start1 = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("w1 idle", {30'd0, busy1, done1}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
